// File: rtl/param_fifo.sv
// Single-clock valid/ready FIFO with first-word-fall-through read side, any DEPTH >= 2,
// almost-full/almost-empty flags, free-slot count, synchronous flush and a high-water monitor.
module param_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_val,
  output logic                       in_rdy,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_val,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH+1)-1:0] free,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] high_water,
  input  logic                       hw_clr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("param_fifo: DEPTH must be >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
      $error("param_fifo: AF_THRESH must be in 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
      $error("param_fifo: AE_THRESH must be in 0..DEPTH-1");
    end
  endgenerate

  // Wrap explicitly at DEPTH-1 so non-power-of-2 depths never index past the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1'b1);
    end
  endfunction

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
  logic [CW-1:0]    count_r, count_next_s, hw_r, hw_next_s, free_r;
  logic             in_rdy_r, out_val_r, af_r, ae_r;
  logic             push_s, pop_s;

  // Handshake decode and next-state for pointers, occupancy and high-water mark.
  always_comb begin
    push_s        = in_val & in_rdy_r;
    pop_s         = out_rdy & out_val_r;
    wr_ptr_next_s = wr_ptr_r;
    rd_ptr_next_s = rd_ptr_r;
    count_next_s  = count_r;
    if (flush) begin
      wr_ptr_next_s = {PW{1'b0}};
      rd_ptr_next_s = {PW{1'b0}};
      count_next_s  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_next_s = ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_next_s = ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_next_s = count_r + CW'(1'b1);
        2'b01:   count_next_s = count_r - CW'(1'b1);
        default: count_next_s = count_r;
      endcase
    end
    if (hw_clr) begin
      hw_next_s = count_next_s;
    end else if (count_next_s > hw_r) begin
      hw_next_s = count_next_s;
    end else begin
      hw_next_s = hw_r;
    end
  end

  // State registers; status outputs are registered from next count so they carry no input paths.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r  <= {PW{1'b0}};
      rd_ptr_r  <= {PW{1'b0}};
      count_r   <= {CW{1'b0}};
      hw_r      <= {CW{1'b0}};
      free_r    <= CW'(DEPTH);
      in_rdy_r  <= 1'b1;
      out_val_r <= 1'b0;
      af_r      <= 1'b0;
      ae_r      <= 1'b1;
    end else begin
      wr_ptr_r  <= wr_ptr_next_s;
      rd_ptr_r  <= rd_ptr_next_s;
      count_r   <= count_next_s;
      hw_r      <= hw_next_s;
      free_r    <= CW'(DEPTH) - count_next_s;
      in_rdy_r  <= (count_next_s != CW'(DEPTH));
      out_val_r <= (count_next_s != {CW{1'b0}});
      af_r      <= (count_next_s >= CW'(AF_THRESH));
      ae_r      <= (count_next_s <= CW'(AE_THRESH));
    end
  end

  // Storage array; contents are don't-care after reset or flush since pointers are cleared.
  always_ff @(posedge clk) begin
    if (rst_n && push_s && !flush) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  assign in_rdy       = in_rdy_r;
  assign out_val      = out_val_r;
  assign out_data     = mem_r[rd_ptr_r];
  assign count        = count_r;
  assign free         = free_r;
  assign almost_full  = af_r;
  assign almost_empty = ae_r;
  assign high_water   = hw_r;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo (WIDTH=8, DEPTH=5, AF=4, AE=1): vector table with
// expected count/high-water columns plus a behavioural queue model scoring every pop.
module tb_param_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n, flush, in_val, out_rdy, hw_clr;
  logic [WIDTH-1:0] in_data, out_data;
  logic             in_rdy, out_val, almost_full, almost_empty;
  logic [CW-1:0]    count, free, high_water;

  param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_val(in_val),
    .in_rdy(in_rdy), .out_data(out_data), .out_val(out_val), .out_rdy(out_rdy),
    .count(count), .free(free), .almost_full(almost_full), .almost_empty(almost_empty),
    .high_water(high_water), .hw_clr(hw_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    logic       hc;
    int         exp_count;
    int         exp_hw;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb_q[$];
  int         cnt_m = 0;
  int         hw_m  = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic iv, input logic [7:0] d, input logic ordy,
                              input logic fl, input logic hc, input int ec, input int eh);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl; v.hc = hc;
    v.exp_count = ec; v.exp_hw = eh;
    vecs.push_back(v);
  endfunction

  // Compare every status output against the model (called at negedge, outputs stable).
  task automatic check_status(input string tag);
    chk({tag, ":count"},        int'(count),        cnt_m);
    chk({tag, ":in_rdy"},       int'(in_rdy),       (cnt_m != DEPTH) ? 1 : 0);
    chk({tag, ":out_val"},      int'(out_val),      (cnt_m != 0) ? 1 : 0);
    chk({tag, ":free"},         int'(free),         DEPTH - cnt_m);
    chk({tag, ":almost_full"},  int'(almost_full),  (cnt_m >= AF) ? 1 : 0);
    chk({tag, ":almost_empty"}, int'(almost_empty), (cnt_m <= AE) ? 1 : 0);
    chk({tag, ":high_water"},   int'(high_water),   hw_m);
  endtask

  // Drive one cycle of stimulus, update the model and score any pop against the queue head.
  task automatic apply(input vec_t v, input int idx);
    bit push, pop;
    in_val = v.iv; in_data = v.d; out_rdy = v.ordy; flush = v.fl; hw_clr = v.hc;
    push = v.iv && (cnt_m != DEPTH);
    pop  = v.ordy && (cnt_m != 0);
    if (pop && !v.fl) begin
      chk($sformatf("v%0d:out_data", idx), int'(out_data), int'(sb_q[0]));
    end
    if (v.fl) begin
      sb_q.delete();
    end else begin
      if (pop) void'(sb_q.pop_front());
      if (push) sb_q.push_back(v.d);
    end
    cnt_m = sb_q.size();
    if (v.hc || cnt_m > hw_m) hw_m = cnt_m;
    @(posedge clk);
    @(negedge clk);
    check_status($sformatf("v%0d", idx));
    chk($sformatf("v%0d:tbl_count", idx), int'(count), v.exp_count);
    chk($sformatf("v%0d:tbl_hw", idx),    int'(high_water), v.exp_hw);
  endtask

  initial begin
    vec_t v;
    // Reset held two cycles with in_val asserted.
    rst_n = 1'b0; flush = 1'b0; in_val = 1'b1; in_data = 8'h77; out_rdy = 1'b0; hw_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; in_val = 1'b0;
    check_status("reset");

    // Fill to full, attempt push while full, then drain and pop on empty.
    add(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1, 1);
    add(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 2, 2);
    add(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 3, 3);
    add(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 4, 4);
    add(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 5, 5);
    add(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 5, 5);
    for (int i = 4; i >= 0; i--) add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, i, 5);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 5);
    // Pointer wrap: 3 in/3 out then 5 in/5 out.
    for (int i = 1; i <= 3; i++) add(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0, i, 5);
    for (int i = 2; i >= 0; i--) add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, i, 5);
    for (int i = 1; i <= 5; i++) add(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, 1'b0, i, 5);
    for (int i = 4; i >= 0; i--) add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, i, 5);
    // Full with pop and in_val: one pop, no push.
    for (int i = 1; i <= 5; i++) add(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0, i, 5);
    add(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 4, 5);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3, 5);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2, 5);
    // Simultaneous push+pop at count 2, then drain through 0xA5.
    add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 2, 5);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 5);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 5);
    // High-water clear, refill to 3, flush with push+pop, clear again.
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 0);
    for (int i = 1; i <= 3; i++) add(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b0, i, i);
    add(1'b1, 8'hD4, 1'b1, 1'b1, 1'b0, 0, 3);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 3);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 0);
    // Post-flush traffic starts from clean pointers.
    add(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0, 1, 1);
    add(1'b1, 8'hE2, 1'b1, 1'b0, 1'b0, 1, 1);
    add(1'b1, 8'hE3, 1'b0, 1'b0, 1'b0, 2, 2);

    foreach (vecs[i]) apply(vecs[i], i);

    // Mid-traffic reset with push, pop and in_val all active.
    rst_n = 1'b0; in_val = 1'b1; in_data = 8'hF0; out_rdy = 1'b1; flush = 1'b0; hw_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; in_val = 1'b0; out_rdy = 1'b0;
    chk("midrst:count",        int'(count),        0);
    chk("midrst:in_rdy",       int'(in_rdy),       1);
    chk("midrst:out_val",      int'(out_val),      0);
    chk("midrst:free",         int'(free),         DEPTH);
    chk("midrst:almost_full",  int'(almost_full),  0);
    chk("midrst:almost_empty", int'(almost_empty), 1);
    chk("midrst:high_water",   int'(high_water),   0);

    // First-word latency after reset: one push is visible the next cycle.
    sb_q.delete(); cnt_m = 0; hw_m = 0;
    v.iv = 1'b1; v.d = 8'h5A; v.ordy = 1'b0; v.fl = 1'b0; v.hc = 1'b0; v.exp_count = 1; v.exp_hw = 1;
    apply(v, 900);
    chk("latency:out_data", int'(out_data), 8'h5A);
    v.iv = 1'b0; v.ordy = 1'b1; v.exp_count = 0;
    apply(v, 901);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
